// File: rtl/cam_pixel_capture_pkg.sv
// Shared types for the DVP camera capture block.
// Capture FSM states and RGB565 field positions.
package cam_pixel_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SYNC      = 2'd1,
        ST_WAIT_LINE = 2'd2,
        ST_LINE      = 2'd3
    } cap_state_t;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

endpackage

// File: rtl/cam_pixel_capture_rgb565_expand.sv
// RGB565 to RGB888 widening by MSB replication.
// Purely combinational, one instance in cam_pixel_capture.
module rgb565_expand
    import cam_pixel_capture_pkg::*;
(
    input  logic [15:0] pix565,
    output logic [7:0]  r8,
    output logic [7:0]  g8,
    output logic [7:0]  b8
);

    assign r8 = {pix565[R_MSB:R_LSB], pix565[R_MSB -: 3]};
    assign g8 = {pix565[G_MSB:G_LSB], pix565[G_MSB -: 2]};
    assign b8 = {pix565[B_MSB:B_LSB], pix565[B_MSB -: 3]};

endmodule

// File: rtl/cam_pixel_capture.sv
// DVP byte stream capture: RGB565 pairs -> RGB888 pixels with x/y.
// Optional CAM_FRAME_STATS_EN latches line_len / frame_lines.
module cam_pixel_capture
    import cam_pixel_capture_pkg::*;
#(
    parameter int   X_BITS   = 12,
    parameter int   Y_BITS   = 12,
    parameter logic VS_POL   = 1'b1,
    parameter logic HI_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_byte_valid,
    input  logic [7:0]        cam_data,
    input  logic              err_clr,
    output logic              pix_valid,
    output logic              pix_sof,
    output logic [7:0]        r_out,
    output logic [7:0]        g_out,
    output logic [7:0]        b_out,
    output logic [X_BITS-1:0] x_out,
    output logic [Y_BITS-1:0] y_out,
    output logic              line_done,
    output logic              frame_done,
    output logic              odd_byte_err,
    output logic              x_ovf_err,
    output logic [X_BITS-1:0] line_len,
    output logic [Y_BITS-1:0] frame_lines
);

    localparam logic [X_BITS-1:0] X_MAX = '1;
    localparam logic [Y_BITS-1:0] Y_MAX = '1;

    cap_state_t        state_q, state_d;
    logic              vs_act, hr_q, hr_rise, hr_fall;
    logic              line_end, frame_end, byte_acc;
    logic              phase_q, full_q, full_nx;
    logic              pair_done, pix_emit, ovf, dangling;
    logic [7:0]        first_q;
    logic [15:0]       pix565;
    logic [7:0]        r8, g8, b8;
    logic [X_BITS-1:0] x_q, x_nx;
    logic [Y_BITS-1:0] y_q;

    assign vs_act  = (cam_vsync == VS_POL);
    assign hr_rise = cam_href & ~hr_q;
    assign hr_fall = ~cam_href & hr_q;

    // href history for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hr_q <= 1'b0;
        else        hr_q <= cam_href;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state plus line/frame end strobes
    always_comb begin
        state_d   = state_q;
        line_end  = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && vs_act) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (!vs_act) state_d = ST_WAIT_LINE;
            end
            ST_WAIT_LINE: begin
                if (vs_act) begin
                    frame_end = 1'b1;
                    state_d   = enable ? ST_SYNC : ST_IDLE;
                end else if (hr_rise) begin
                    state_d = ST_LINE;
                end
            end
            ST_LINE: begin
                if (vs_act) begin
                    frame_end = 1'b1;
                    line_end  = 1'b1;
                    state_d   = enable ? ST_SYNC : ST_IDLE;
                end else if (hr_fall) begin
                    line_end = 1'b1;
                    state_d  = ST_WAIT_LINE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign byte_acc  = (state_q == ST_LINE) && cam_byte_valid;
    assign pair_done = byte_acc & phase_q;
    assign pix_emit  = pair_done & ~full_q;
    assign ovf       = pair_done & full_q;
    // a byte landing on the line-end cycle is counted before the check
    assign dangling  = phase_q ^ byte_acc;
    assign pix565    = HI_FIRST ? {first_q, cam_data} : {cam_data, first_q};

    // Column advance; the last column latches "full" instead of wrapping
    always_comb begin
        x_nx    = x_q;
        full_nx = full_q;
        if (pix_emit) begin
            if (x_q == X_MAX) full_nx = 1'b1;
            else              x_nx    = x_q + 1'b1;
        end
    end

    rgb565_expand u_expand (
        .pix565 (pix565),
        .r8     (r8),
        .g8     (g8),
        .b8     (b8)
    );

    // Byte pairing, coordinates, pixel outputs and sticky errors
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_valid    <= 1'b0;
            pix_sof      <= 1'b0;
            line_done    <= 1'b0;
            frame_done   <= 1'b0;
            r_out        <= '0;
            g_out        <= '0;
            b_out        <= '0;
            x_out        <= '0;
            y_out        <= '0;
            first_q      <= '0;
            phase_q      <= 1'b0;
            full_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            odd_byte_err <= 1'b0;
            x_ovf_err    <= 1'b0;
        end else begin
            pix_valid  <= pix_emit;
            pix_sof    <= pix_emit && (x_q == '0) && (y_q == '0);
            line_done  <= line_end;
            frame_done <= frame_end;
            if (pix_emit) begin
                r_out <= r8;
                g_out <= g8;
                b_out <= b8;
                x_out <= x_q;
                y_out <= y_q;
            end
            if (byte_acc && !phase_q) first_q <= cam_data;
            if (line_end || frame_end) phase_q <= 1'b0;
            else if (byte_acc)         phase_q <= ~phase_q;
            if (line_end) begin
                x_q    <= '0;
                full_q <= 1'b0;
            end else begin
                x_q    <= x_nx;
                full_q <= full_nx;
            end
            if (frame_end)
                y_q <= '0;
            else if (line_end && (y_q != Y_MAX))
                y_q <= y_q + 1'b1;
            if (err_clr) begin
                odd_byte_err <= 1'b0;
                x_ovf_err    <= 1'b0;
            end else begin
                if (line_end && dangling) odd_byte_err <= 1'b1;
                if (ovf)                  x_ovf_err    <= 1'b1;
            end
        end
    end

`ifdef CAM_FRAME_STATS_EN
    logic [X_BITS-1:0] cnt_now;
    logic [Y_BITS-1:0] lines_q, lines_nx;

    assign cnt_now  = full_nx ? X_MAX : x_nx;
    assign lines_nx = (line_end && (lines_q != Y_MAX)) ?
                      lines_q + 1'b1 : lines_q;

    // Per-line pixel count and per-frame line count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_len    <= '0;
            frame_lines <= '0;
            lines_q     <= '0;
        end else begin
            if (line_end) line_len <= cnt_now;
            if (frame_end) begin
                frame_lines <= lines_nx;
                lines_q     <= '0;
            end else begin
                lines_q <= lines_nx;
            end
        end
    end
`else
    assign line_len    = '0;
    assign frame_lines = '0;
`endif

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Bench for cam_pixel_capture (X_BITS=3), frame-level model + scoreboard.
// Stats expectations follow CAM_FRAME_STATS_EN.
module tb_cam_pixel_capture;

    localparam int XB   = 3;
    localparam int YB   = 12;
    localparam int XCAP = 1 << XB;

    typedef struct packed {
        logic [7:0]    r;
        logic [7:0]    g;
        logic [7:0]    b;
        logic [XB-1:0] x;
        logic [YB-1:0] y;
        logic          sof;
    } px_t;

    logic          clk = 1'b0;
    logic          reset, enable, cam_vsync, cam_href, cam_byte_valid, err_clr;
    logic [7:0]    cam_data;
    logic          pix_valid, pix_sof, line_done, frame_done;
    logic          odd_byte_err, x_ovf_err;
    logic [7:0]    r_out, g_out, b_out;
    logic [XB-1:0] x_out, line_len;
    logic [YB-1:0] y_out, frame_lines;

    cam_pixel_capture #(.X_BITS(XB), .Y_BITS(YB), .VS_POL(1'b1), .HI_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_byte_valid(cam_byte_valid), .cam_data(cam_data),
        .err_clr(err_clr), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .x_out(x_out), .y_out(y_out),
        .line_done(line_done), .frame_done(frame_done), .odd_byte_err(odd_byte_err),
        .x_ovf_err(x_ovf_err), .line_len(line_len), .frame_lines(frame_lines)
    );

    always #10 clk = ~clk;

    int  n_cmp = 0, n_bad = 0;
    int  cyc = 0, mon_ld = 0, mon_fd = 0, ld_cyc = 0, fd_cyc = 0;
    px_t expq[$];
    px_t seen[$];

    // model state
    bit  m_cap = 0;
    int  m_y = 0, m_lines = 0, e_ld = 0, e_fd = 0, e_len = 0, e_fl = 0;
    bit  e_odd = 0, e_ovf = 0;
    logic [7:0] lb [0:31];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] exp565(input logic [15:0] p);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(p) / 2048;
        g6 = (int'(p) / 32) % 64;
        b5 = int'(p) % 32;
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return {r8[7:0], g8[7:0], b8[7:0]};
    endfunction

    // scoreboard: every pix_valid is matched against the model queue
    always @(negedge clk) begin
        px_t e, a;
        cyc++;
        if (line_done) begin mon_ld++; ld_cyc = cyc; end
        if (frame_done) begin mon_fd++; fd_cyc = cyc; end
        if (pix_valid) begin
            a = '{r: r_out, g: g_out, b: b_out, x: x_out, y: y_out, sof: pix_sof};
            seen.push_back(a);
            n_cmp++;
            if (expq.size() == 0) begin
                n_bad++;
                $display("FAIL pix_unexpected: got %h want none", a);
            end else begin
                e = expq.pop_front();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL pix: got %h want %h", a, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_vsync();
        if (m_cap) begin
            e_fd++;
            e_fl = m_lines;
            m_lines = 0;
            m_y = 0;
        end
        m_cap = enable;
    endtask

    task automatic model_line(input int n, input bit vs_end, input bit clr);
        px_t e;
        int  np;
        if (m_cap) begin
            np = n / 2;
            for (int k = 0; k < np; k++) begin
                if (k < XCAP) begin
                    {e.r, e.g, e.b} = exp565({lb[2*k], lb[2*k+1]});
                    e.x   = XB'(k);
                    e.y   = YB'(m_y);
                    e.sof = (k == 0) && (m_y == 0);
                    expq.push_back(e);
                end else begin
                    e_ovf = 1;
                end
            end
            if (n % 2 == 1) e_odd = 1;
            if (clr) begin e_odd = 0; e_ovf = 0; end
            e_ld++;
            e_len = (np > XCAP - 1) ? XCAP - 1 : np;
            m_lines++;
            m_y++;
        end
        if (vs_end) model_vsync();
    endtask

    task automatic vsync_pulse();
        model_vsync();
        cam_vsync = 1'b1;
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic send_line(input int n, input bit fall_last, input bit vs_end, input bit clr);
        model_line(n, vs_end, clr);
        cam_href = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            cam_data = lb[i];
            cam_byte_valid = 1'b1;
            if (i == n - 1 && fall_last) begin
                cam_href = 1'b0;
                err_clr = clr;
            end
            tick();
            cam_byte_valid = 1'b0;
            err_clr = 1'b0;
            if (!(i == n - 1 && fall_last)) tick();
        end
        if (!fall_last) begin
            if (vs_end) cam_vsync = 1'b1;
            else        cam_href = 1'b0;
            err_clr = clr;
            tick();
            err_clr = 1'b0;
        end
        if (vs_end) begin
            repeat (2) tick();
            cam_href = 1'b0;
            tick();
            cam_vsync = 1'b0;
            tick();
        end
        repeat (2) tick();
    endtask

    task automatic fill(input int n, input int seed);
        for (int i = 0; i < n; i++) lb[i] = 8'((seed * 37 + i * 29 + 5) % 256);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        e_odd = 0;
        e_ovf = 0;
    endtask

    task automatic chk_state(input string nm);
        chk({nm, "_odd"}, odd_byte_err, e_odd);
        chk({nm, "_ovf"}, x_ovf_err, e_ovf);
        chk({nm, "_ld"}, mon_ld, e_ld);
        chk({nm, "_fd"}, mon_fd, e_fd);
        chk({nm, "_q"}, expq.size(), 0);
`ifdef CAM_FRAME_STATS_EN
        chk({nm, "_len"}, line_len, e_len);
        chk({nm, "_fl"}, frame_lines, e_fl);
`else
        chk({nm, "_len"}, line_len, 0);
        chk({nm, "_fl"}, frame_lines, 0);
`endif
    endtask

    function automatic logic [63:0] all_out();
        return {pix_valid, pix_sof, r_out, g_out, b_out, x_out, y_out, line_done,
                frame_done, odd_byte_err, x_ovf_err, line_len, frame_lines};
    endfunction

    initial begin
        int fd0;
        reset = 1'b0; enable = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
        cam_byte_valid = 1'b0; cam_data = 8'h00; err_clr = 1'b0;
        repeat (3) tick();
        chk("reset_outs", all_out(), 64'd0);
        reset = 1'b1;
        tick();

        // 4-pixel primary-colour line
        enable = 1'b1;
        vsync_pulse();
        lb[0] = 8'hF8; lb[1] = 8'h00; lb[2] = 8'h07; lb[3] = 8'hE0;
        lb[4] = 8'h00; lb[5] = 8'h1F; lb[6] = 8'hFF; lb[7] = 8'hFF;
        seen.delete();
        send_line(8, 0, 0, 0);
        chk("four_cnt", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("px0_rgb", {seen[0].r, seen[0].g, seen[0].b}, 24'hFF0000);
            chk("px1_rgb", {seen[1].r, seen[1].g, seen[1].b}, 24'h00FF00);
            chk("px2_rgb", {seen[2].r, seen[2].g, seen[2].b}, 24'h0000FF);
            chk("px3_rgb", {seen[3].r, seen[3].g, seen[3].b}, 24'hFFFFFF);
            chk("px0_sof", seen[0].sof, 1'b1);
            chk("px1_sof", seen[1].sof, 1'b0);
            chk("px3_x", seen[3].x, 3);
        end
        chk("four_ld", mon_ld, 1);
        chk_state("four");

        // odd byte handling and error clear priority
        fill(3, 1);
        send_line(3, 0, 0, 0);
        chk("odd_set", odd_byte_err, 1'b1);
        pulse_clr();
        chk("odd_clr", odd_byte_err, 1'b0);
        fill(3, 2);
        send_line(3, 0, 0, 1);
        chk("odd_clr_wins", odd_byte_err, 1'b0);
        fill(4, 3);
        send_line(4, 1, 0, 0);
        chk_state("fall_byte");

        // column saturation
        fill(18, 4);
        seen.delete();
        send_line(18, 0, 0, 0);
        chk("ovf_npix", seen.size(), 8);
        chk("ovf_xlast", x_out, 7);
        chk("ovf_flag", x_ovf_err, 1'b1);
        chk_state("ovf");
        pulse_clr();

        // two frames of 3 lines x 5 pixels
        vsync_pulse();
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < 3; l++) begin
                fill(10, f * 3 + l + 10);
                send_line(10, 0, 0, 0);
            end
            vsync_pulse();
        end
`ifdef CAM_FRAME_STATS_EN
        chk("stats_len", line_len, 5);
        chk("stats_fl", frame_lines, 3);
`else
        chk("stats_len_off", line_len, 0);
        chk("stats_fl_off", frame_lines, 0);
`endif
        chk_state("stats");

        // vsync mid-line
        fill(4, 20);
        send_line(4, 0, 0, 0);
        fd0 = mon_fd;
        fill(3, 21);
        send_line(3, 0, 1, 0);
        chk("mid_fd", mon_fd, fd0 + 1);
        chk("mid_same_cyc", ld_cyc, fd_cyc);
        chk_state("mid");
        pulse_clr();
        fill(6, 22);
        send_line(6, 0, 0, 0);
        enable = 1'b0;
        fill(4, 23);
        send_line(4, 0, 0, 0);
        fill(2, 24);
        send_line(2, 0, 1, 0);
        fill(6, 25);
        send_line(6, 0, 0, 0);
        vsync_pulse();
        fill(6, 26);
        send_line(6, 0, 0, 0);
        chk_state("idle");

        // reset mid-line
        enable = 1'b1;
        vsync_pulse();
        fill(3, 27);
        send_line(3, 0, 0, 0);
        chk("pre_rst_odd", odd_byte_err, 1'b1);
        cam_href = 1'b1;
        tick();
        cam_data = 8'hA5;
        cam_byte_valid = 1'b1;
        tick();
        cam_byte_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midline_rst", all_out(), 64'd0);
        cam_href = 1'b0;
        expq.delete();
        m_cap = 0; m_y = 0; m_lines = 0;
        e_odd = 0; e_ovf = 0; e_len = 0; e_fl = 0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        fill(6, 28);
        send_line(6, 0, 0, 0);
        chk_state("post_rst");
        vsync_pulse();
        fill(6, 29);
        send_line(6, 0, 0, 0);
        chk_state("restart");

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
